// File: rtl/vram_seq_pkg.sv
// Shared types and constants for the VRAM op sequencer.
// Optional VRAM_SEQ_VSYNC_ALIGN_EN adds the WAIT_VS state.
package vram_seq_pkg;

  localparam int VRAM_WORDS    = 1200;
  localparam int LAST_COPY_DST = 1159;

  typedef enum logic [1:0] {
    OP_FILL_ALL  = 2'd0,
    OP_FILL_ROW  = 2'd1,
    OP_SCROLL_UP = 2'd2,
    OP_RSVD      = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COPY_RD = 3'd1,
    ST_COPY_WR = 3'd2,
    ST_FILL    = 3'd3,
`ifdef VRAM_SEQ_VSYNC_ALIGN_EN
    ST_DONE    = 3'd4,
    ST_WAIT_VS = 3'd5
`else
    ST_DONE    = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/vram_port_mux.sv
// Port-A arbiter: the CPU always wins; the engine gets the port only on
// cycles with no CPU access. Engine accesses are always full-word.
module vram_port_mux #(
  parameter int ADDR_W = 11
) (
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_byteen,
  input  logic [31:0]       cpu_wdata,
  input  logic              eng_rden,
  input  logic              eng_wren,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [31:0]       eng_wdata,
  output logic              eng_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byteen,
  output logic [31:0]       mem_wdata,
  output logic              mem_rden,
  output logic              mem_wren
);

  // Select CPU or engine onto port A
  always_comb begin
    eng_gnt = ~(cpu_rd | cpu_wr);
    if (eng_gnt) begin
      mem_addr   = eng_addr;
      mem_byteen = 4'hF;
      mem_wdata  = eng_wdata;
      mem_rden   = eng_rden;
      mem_wren   = eng_wren;
    end else begin
      mem_addr   = cpu_addr;
      mem_byteen = cpu_byteen;
      mem_wdata  = cpu_wdata;
      mem_rden   = cpu_rd;
      mem_wren   = cpu_wr;
    end
  end

endmodule

// File: rtl/vram_op_sequencer.sv
// VRAM command engine (fill all, fill row, scroll up) sharing port A with
// the CPU. Optional VRAM_SEQ_VSYNC_ALIGN_EN holds accepted commands until
// the next falling edge of vs.
module vram_op_sequencer
  import vram_seq_pkg::*;
#(
  parameter int ROW_WORDS = 40,
  parameter int NUM_ROWS  = 30,
  parameter int ADDR_W    = 11
) (
  input  logic              CLK,
  input  logic              RESET,
`ifdef VRAM_SEQ_VSYNC_ALIGN_EN
  input  logic              vs,
`endif
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_byteen,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [4:0]        cmd_row,
  input  logic [31:0]       cmd_fill,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byteen,
  output logic [31:0]       mem_wdata,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [31:0]       mem_q,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dst_q, dst_d, end_q, end_d;
  logic [31:0]       hold_q, hold_d, fill_q, fill_d;
  logic              rd_pend_q, rd_pend_d;

  logic              eng_gnt, eng_rden, eng_wren;
  logic [ADDR_W-1:0] eng_addr;
  logic [31:0]       eng_wdata;

  op_e               dec_op;
  logic [4:0]        dec_row;
  state_e            dec_state;
  logic [ADDR_W-1:0] dec_dst, dec_end, row_ext, row_base;

`ifdef VRAM_SEQ_VSYNC_ALIGN_EN
  op_e        op_q, op_d;
  logic [4:0] row_q, row_d;
  logic       vs_q;
  logic       vs_fall;
  assign vs_fall = vs_q & ~vs;
  assign dec_op  = op_q;
  assign dec_row = row_q;
`else
  assign dec_op  = op_e'(cmd_op);
  assign dec_row = cmd_row;
`endif

  assign cpu_rdata = mem_q;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);

  // Translate a command into its start state and address window
  always_comb begin
    row_ext   = ADDR_W'(dec_row);
    row_base  = (row_ext << 5) + (row_ext << 3);
    dec_state = ST_DONE;
    dec_dst   = '0;
    dec_end   = '0;
    case (dec_op)
      OP_FILL_ALL: begin
        dec_state = ST_FILL;
        dec_end   = ADDR_W'(VRAM_WORDS - 1);
      end
      OP_FILL_ROW: begin
        // Out-of-range rows complete without touching memory
        if (dec_row < 5'(NUM_ROWS)) begin
          dec_state = ST_FILL;
          dec_dst   = row_base;
          dec_end   = row_base + ADDR_W'(ROW_WORDS - 1);
        end
      end
      OP_SCROLL_UP: dec_state = ST_COPY_RD;
      default:      dec_state = ST_DONE;
    endcase
  end

  // Next-state, counters and engine port requests
  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    end_d     = end_q;
    fill_d    = fill_q;
    rd_pend_d = 1'b0;
    // Read data lands one cycle after issue, whoever owns the port then
    hold_d    = rd_pend_q ? mem_q : hold_q;
    eng_rden  = 1'b0;
    eng_wren  = 1'b0;
    eng_addr  = dst_q;
    eng_wdata = fill_q;
`ifdef VRAM_SEQ_VSYNC_ALIGN_EN
    op_d      = op_q;
    row_d     = row_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          fill_d = cmd_fill;
`ifdef VRAM_SEQ_VSYNC_ALIGN_EN
          op_d    = op_e'(cmd_op);
          row_d   = cmd_row;
          state_d = ST_WAIT_VS;
`else
          state_d = dec_state;
          dst_d   = dec_dst;
          end_d   = dec_end;
`endif
        end
      end
`ifdef VRAM_SEQ_VSYNC_ALIGN_EN
      ST_WAIT_VS: begin
        if (vs_fall) begin
          state_d = dec_state;
          dst_d   = dec_dst;
          end_d   = dec_end;
        end
      end
`endif
      ST_COPY_RD: begin
        eng_rden = 1'b1;
        eng_addr = dst_q + ADDR_W'(ROW_WORDS);
        if (eng_gnt) begin
          rd_pend_d = 1'b1;
          state_d   = ST_COPY_WR;
        end
      end
      ST_COPY_WR: begin
        // Forward fresh read data so an uncontested copy takes two cycles
        eng_wren  = 1'b1;
        eng_wdata = rd_pend_q ? mem_q : hold_q;
        if (eng_gnt) begin
          if (dst_q == ADDR_W'(LAST_COPY_DST)) begin
            dst_d   = ADDR_W'(LAST_COPY_DST + 1);
            end_d   = ADDR_W'(VRAM_WORDS - 1);
            state_d = ST_FILL;
          end else begin
            dst_d   = dst_q + 1'b1;
            state_d = ST_COPY_RD;
          end
        end
      end
      ST_FILL: begin
        eng_wren = 1'b1;
        if (eng_gnt) begin
          if (dst_q == end_q) state_d = ST_DONE;
          else                dst_d   = dst_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A reset cycle must not let a pending engine access reach the RAM
  vram_port_mux #(.ADDR_W(ADDR_W)) u_mux (
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_byteen (cpu_byteen),
    .cpu_wdata  (cpu_wdata),
    .eng_rden   (eng_rden & ~RESET),
    .eng_wren   (eng_wren & ~RESET),
    .eng_addr   (eng_addr),
    .eng_wdata  (eng_wdata),
    .eng_gnt    (eng_gnt),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren)
  );

  // State and datapath registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      dst_q     <= '0;
      end_q     <= '0;
      hold_q    <= '0;
      fill_q    <= '0;
      rd_pend_q <= 1'b0;
`ifdef VRAM_SEQ_VSYNC_ALIGN_EN
      op_q      <= OP_FILL_ALL;
      row_q     <= '0;
      vs_q      <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      end_q     <= end_d;
      hold_q    <= hold_d;
      fill_q    <= fill_d;
      rd_pend_q <= rd_pend_d;
`ifdef VRAM_SEQ_VSYNC_ALIGN_EN
      op_q      <= op_d;
      row_q     <= row_d;
      vs_q      <= vs;
`endif
    end
  end

endmodule

// File: doc/vram_op_sequencer.md
Name: vram_op_sequencer

Overview:
- Hardware command engine plus arbiter for port A of the text-mode VRAM: 80x30 characters, 2 characters per 32-bit word, 40 words per row, 1200 words.
- Performs screen fill, single-row fill and one-row scroll-up without CPU copy loops.
- Shares port A with the Avalon-MM CPU slave path. The CPU has absolute priority and the engine uses idle cycles.
- Sits between the Avalon slave decode and the on-chip VRAM. The palette path (AVL_ADDR[11]=1) bypasses it.

Parameters:
- ROW_WORDS, 40, words per text row.
- NUM_ROWS, 30, text rows.
- ADDR_W, 11, VRAM word address width.

Ports:
- CLK  in  1  clock, 50 MHz.
- RESET  in  1  synchronous, active-high.
- cpu_rd  in  1  CPU VRAM read (already qualified by CS and ~ADDR[11]).
- cpu_wr  in  1  CPU VRAM write (already qualified by CS and ~ADDR[11]).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_byteen  in  4  CPU byte enables.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  CPU read data, valid 1 cycle after cpu_rd.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine accepts a command.
- cmd_op  in  2  command: 0 FILL_ALL, 1 FILL_ROW, 2 SCROLL_UP, 3 reserved (accepted, no-op, done pulses).
- cmd_row  in  5  row index for FILL_ROW.
- cmd_fill  in  32  fill word (two characters).
- mem_addr  out  ADDR_W  VRAM port A address.
- mem_byteen  out  4  VRAM port A byte enables.
- mem_wdata  out  32  VRAM port A write data.
- mem_rden  out  1  VRAM port A read enable.
- mem_wren  out  1  VRAM port A write enable.
- mem_q  in  32  VRAM port A read data, registered, 1-cycle latency.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse on command completion.

Behaviour:
- Reset state: IDLE. busy=0, done=0, cmd_ready=1, mem_rden=0, mem_wren=0, counters=0.
- Reset asserted mid-command aborts the command: the engine issues no further writes and does not pulse done.
- Arbitration, per cycle:
  - If cpu_rd or cpu_wr is high, port A carries the CPU access combinationally: cpu_addr, cpu_byteen, cpu_wdata, rden=cpu_rd, wren=cpu_wr.
  - Otherwise the engine owns port A.
  - cpu_rdata = mem_q at all times.
  - The CPU never stalls (no waitrequest).
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE).
  - op, row and fill are latched on acceptance.
  - Engine activity starts the next cycle.
- FSM states: IDLE, COPY_RD, COPY_WR, FILL, DONE.
- FILL_ALL:
  - dst=0, end=1199 -> FILL.
- FILL_ROW:
  - dst = row*40, end = dst+39 -> FILL.
  - row >= 30 writes nothing and goes straight to DONE.
- SCROLL_UP:
  - dst=0 -> COPY_RD.
- COPY_RD:
  - On engine grant, issue a read at dst+40, set rd_pend, go to COPY_WR.
- Read capture:
  - In the cycle after the read is issued, mem_q is captured into hold unconditionally, even if the CPU owns the port that cycle.
- COPY_WR:
  - On grant, write hold to dst with byteen 4'hF.
  - If dst==1159: set dst=1160, end=1199, go to FILL. Otherwise dst++ and go to COPY_RD.
- FILL:
  - On grant, write the latched fill word to dst with byteen 4'hF.
  - If dst==end go to DONE, else dst++.
- DONE:
  - done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Throughput, uncontested:
  - FILL_ALL: 1 word/cycle, 1200 cycles.
  - SCROLL_UP: 2 cycles/word for the 1160 copies, then 40 fill cycles.
- A CPU cycle during engine ownership holds the FSM in place; dst, end and hold are unchanged.
- No coherence guarantee: CPU writes to VRAM during a SCROLL_UP may be overwritten by the engine.
- All address arithmetic is ADDR_W bits unsigned. row*40 is computed as (row<<5)+(row<<3).

Optional Feature:
- Macro: VRAM_SEQ_VSYNC_ALIGN_EN.
- When defined:
  - Adds port vs (in, 1, active-low VGA vsync).
  - An accepted command waits in an extra state WAIT_VS until the first falling edge of vs detected after acceptance, then begins.
  - busy=1 and cmd_ready=0 while waiting.
- When not defined: there is no vs port and no WAIT_VS state; commands start the cycle after acceptance.

Decomposition:
- Package vram_seq_pkg:
  - typedef enum logic [1:0] op_e {OP_FILL_ALL, OP_FILL_ROW, OP_SCROLL_UP, OP_RSVD}.
  - typedef enum for the FSM states.
  - Constants VRAM_WORDS=1200 and LAST_COPY_DST=1159.
- Sub-module vram_port_mux: combinational CPU/engine port-A multiplexer producing the engine grant. The FSM, counters and hold register stay in the top.

Test Plan:
- FILL_ALL with fill=32'h0741_0741, no CPU traffic:
  - done pulses after 1200 write cycles.
  - Readback of words 0, 599 and 1199 returns 32'h0741_0741.
- FILL_ROW with row=29, fill=32'hAAAA_5555:
  - Writes occur only at addresses 1160..1199; word 1159 is unchanged.
  - row=30 -> done with zero writes.
- SCROLL_UP with word i preloaded to i and fill=0:
  - After done, word 0 = 40, word 1159 = 1199, words 1160..1199 = 0.
- SCROLL_UP with a CPU read on the cycle the engine read data returns, plus cpu_wr bursts every third cycle:
  - Copy result is still correct.
  - Each CPU read returns its own address data one cycle later.
- RESET pulsed at dst=500 of FILL_ALL:
  - No writes and no done pulse afterwards; busy=0; cmd_ready=1 the next cycle.
- With VRAM_SEQ_VSYNC_ALIGN_EN defined:
  - The command is accepted at a cycle when vs=1.
  - The first engine write occurs 1 cycle after the vs falling edge is detected.
  - cmd_ready stays 0 throughout the wait.
